// File: rtl/mdu_iter.sv
// -----------------------------------------------------------------------------
// mdu_iter : iterative multiply/divide unit for the M extension (XLEN generic)
//
// Runs one operation at a time. A radix-2 shift-add multiplier or a restoring
// divider spends XLEN cycles in CALC, then one FIX cycle applies the sign
// correction and registers the result. Divide-by-zero and signed overflow are
// resolved at accept time and reach DONE on the next cycle.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (wins over flush and handshakes)
//   flush      abort any in-flight or finished-but-unconsumed operation
//   in_valid   request valid            in_ready  unit can accept a request
//   op         0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//   a, b       rs1 / dividend, rs2 / divisor
//   out_valid  result valid             out_ready consumer takes the result
//   result     operation result (held after the result is consumed)
//   busy       unit is in any state other than IDLE
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE with flush low, so a flush in IDLE
// blocks that cycle's accept. out_valid is high only in DONE, and result is
// stable while out_valid && !out_ready. There is no accept in the same cycle
// as the result is consumed.
//
// XLEN must be even and at least 4. CNTW is derived and must not be overridden.
// -----------------------------------------------------------------------------
module mdu_iter #(
  parameter int XLEN = 32,
  parameter int CNTW = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [XLEN-1:0] ALL_ONES  = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNTW-1:0] LAST_ITER = CNTW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;         // operand signs differ
  logic                sign_a_q, sign_a_d;   // a was negative and signed
  logic [XLEN-1:0]     opnd_q, opnd_d;       // |a| multiplicand or |b| divisor
  logic [2*XLEN-1:0]   acc_q, acc_d;         // product, or {remainder, dividend/quotient}
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]     result_q, result_d;

  // ---------------------------------------------------------------------------
  // Accept-time decode: operand signs, magnitudes and special cases.
  // ---------------------------------------------------------------------------
  logic            a_signed, b_signed, sa, sb, is_div;
  logic            div_by_zero, div_ovf, special;
  logic [XLEN-1:0] abs_a, abs_b, special_res;

  always_comb begin
    a_signed    = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_signed    = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    sa          = a_signed && a[XLEN-1];
    sb          = b_signed && b[XLEN-1];
    abs_a       = sa ? -a : a;
    abs_b       = sb ? -b : b;
    is_div      = op[2];
    div_by_zero = is_div && (b == '0);
    // Only signed DIV/REM (op[0]==0) can overflow: MIN_NEG / -1.
    div_ovf     = is_div && !op[0] && (a == MIN_NEG) && (b == ALL_ONES);
    special     = div_by_zero || div_ovf;
    // op[1] selects the remainder flavour among the divide ops.
    if (div_by_zero) begin
      special_res = op[1] ? a : ALL_ONES;
    end else begin
      special_res = op[1] ? '0 : a;
    end
  end

  // ---------------------------------------------------------------------------
  // One iteration step for each datapath.
  // Multiply: acc = {partial, multiplier}; add the multiplicand into the upper
  // half when the multiplier LSB is set, then shift the whole thing right.
  // Divide: acc = {remainder, dividend}; shift the next dividend bit into the
  // remainder, trial-subtract the divisor, and shift the quotient bit in at the
  // bottom as the dividend bits move out at the top.
  // ---------------------------------------------------------------------------
  logic [XLEN:0]     add_sum, rem_shift, trial;
  logic [2*XLEN-1:0] mul_next, div_next;

  always_comb begin
    add_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
    mul_next  = acc_q[0] ? {add_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    rem_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    trial     = rem_shift - {1'b0, opnd_q};
    // trial[XLEN] set means the difference went negative: restore.
    if (trial[XLEN]) begin
      div_next = {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      div_next = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
  end

  // ---------------------------------------------------------------------------
  // Sign correction and result selection used in FIX.
  // ---------------------------------------------------------------------------
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    fix_res  = '0;
    case (op_q)
      OP_MUL:                       fix_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res = quo_fix;
      OP_REM, OP_REMU:              fix_res = rem_fix;
      default:                      fix_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM next state and datapath updates.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    sign_a_d = sign_a_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && !flush) begin
          op_d     = op;
          sign_a_d = sa;
          neg_d    = sa ^ sb;
          cnt_d    = '0;
          opnd_d   = is_div ? abs_b : abs_a;
          acc_d    = {{XLEN{1'b0}}, (is_div ? abs_a : abs_b)};
          if (special) begin
            result_d = special_res;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q + CNTW'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = fix_res;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // An abort leaves the result register exactly as it was, even from FIX.
    if (flush && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      sign_a_q <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      sign_a_q <= sign_a_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !flush;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// -----------------------------------------------------------------------------
// tb_mdu_iter : self-checking bench for mdu_iter (XLEN = 32)
//
// Driver tasks push the expected result and expected latency into queues at
// accept time; a monitor process compares them whenever the DUT presents or
// hands over a result. Inputs change 1 time unit after the rising edge,
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mdu_iter;

  localparam int XLEN = 32;

  // ---------------------------------------------------------------- clock/reset
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      op = 3'd0;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] result;
  logic            busy;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mdu_iter #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [XLEN-1:0] exp_q[$];
  int              lat_q[$];
  int              acc_cyc = 0;
  logic [XLEN-1:0] last_exp = '0;
  int              n_checks = 0;
  int              n_fail = 0;
  bit              hold_rdy = 1'b0;
  bit              rand_rdy = 1'b0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference model: RV32M semantics computed with 64-bit arithmetic.
  function automatic logic [XLEN-1:0] model(input logic [2:0] o, input logic [XLEN-1:0] x,
                                            input logic [XLEN-1:0] y);
    longint          sx, sy;
    longint unsigned ux, uy;
    logic [63:0]     p;
    logic [XLEN-1:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'h0, x};
    uy = {32'h0, y};
    r  = '0;
    case (o)
      3'd0: begin p = ux * uy; r = p[31:0]; end
      3'd1: begin p = sx * sy; r = p[63:32]; end
      3'd2: begin p = sx * longint'(uy); r = p[63:32]; end
      3'd3: begin p = ux * uy; r = p[63:32]; end
      3'd4: begin
        if (y == 0) r = 32'hFFFF_FFFF;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = x;
        else begin p = sx / sy; r = p[31:0]; end
      end
      3'd5: begin
        if (y == 0) r = 32'hFFFF_FFFF;
        else begin p = ux / uy; r = p[31:0]; end
      end
      3'd6: begin
        if (y == 0) r = x;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = '0;
        else begin p = sx % sy; r = p[31:0]; end
      end
      default: begin
        if (y == 0) r = x;
        else begin p = ux % uy; r = p[31:0]; end
      end
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [XLEN-1:0] x,
                                    input logic [XLEN-1:0] y);
    if (o < 3'd4) return 1'b0;
    if (y == 0) return 1'b1;
    return (o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF;
  endfunction

  // ---------------------------------------------------------------- consumer
  always @(posedge clk) begin
    #2;
    if (hold_rdy)      out_ready = 1'b0;
    else if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    else               out_ready = 1'b1;
  end

  // ---------------------------------------------------------------- monitor
  logic ov_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !ov_prev) begin
        if (lat_q.size() == 0) fail_now("unexpected out_valid");
        else check("latency", 32'(cyc - acc_cyc), 32'(lat_q.pop_front()));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected result handover");
        else begin
          last_exp = exp_q.pop_front();
          check("result", result, last_exp);
        end
      end
    end
    ov_prev = out_valid;
  end

  // ---------------------------------------------------------------- drivers
  task automatic issue(input logic [2:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
    int n = 0;
    @(posedge clk); #1;
    op = o; a = x; b = y; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 300) begin
        fail_now("accept timeout");
        in_valid = 1'b0;
        return;
      end
    end
    acc_cyc = cyc;
    exp_q.push_back(model(o, x, y));
    lat_q.push_back(is_special(o, x, y) ? 1 : XLEN + 2);
    @(posedge clk); #1;
    // Scramble the request inputs: the unit must have latched them.
    in_valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) fail_now("drain timeout");
  endtask

  task automatic run_op(input logic [2:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
    issue(o, x, y);
    drain();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " result"},    result,         32'd0);
    check({tag, " busy"},      32'(busy),      32'd0);
    check({tag, " in_ready"},  32'(in_ready),  32'd1);
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached with %0d of %0d checks failing", n_fail, n_checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- sequence
  initial begin
    int n;
    logic [2:0]      ro;
    logic [XLEN-1:0] ra, rb;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Backpressure on MUL 7 * -3.
    hold_rdy = 1'b1;
    issue(3'd0, 32'd7, 32'hFFFF_FFFD);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_now("wait out_valid timeout");
    for (int i = 0; i < 10; i++) begin
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp result",    result,         32'hFFFF_FFEB);
      check("bp in_ready",  32'(in_ready),  32'd0);
      @(negedge clk);
    end
    hold_rdy = 1'b0;
    @(negedge clk);
    check("handover in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("after handover busy",     32'(busy),      32'd0);
    check("after handover in_ready", 32'(in_ready),  32'd1);
    check("after handover out_valid", 32'(out_valid), 32'd0);
    check("result held after DONE",  result,         32'hFFFF_FFEB);

    // Directed operations.
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd5, 32'd100, 32'd7);
    run_op(3'd7, 32'd100, 32'd7);
    run_op(3'd5, 32'd5, 32'd0);
    run_op(3'd6, 32'd5, 32'd0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

    // Flush in CALC cycle 5.
    issue(3'd4, 32'd1000, 32'd3);
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    void'(exp_q.pop_back());
    void'(lat_q.pop_back());
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush out_valid", 32'(out_valid), 32'd0);
    check("flush busy",      32'(busy),      32'd0);
    check("flush in_ready",  32'(in_ready),  32'd1);
    check("flush result",    result,         last_exp);
    run_op(3'd0, 32'd3, 32'd4);

    // Flush while idle blocks the accept.
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
    @(negedge clk);
    check("idle flush in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("idle flush busy", 32'(busy), 32'd0);

    // Reset in the middle of CALC.
    issue(3'd1, $urandom, $urandom);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    void'(exp_q.pop_back());
    void'(lat_q.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid-calc reset");
    last_exp = '0;

    // Randomised traffic with random consumer stalls.
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       begin ra = $urandom; rb = '0; end
        1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2:       begin ra = 32'($urandom_range(0, 40)) - 32'd20; rb = 32'($urandom_range(0, 10)) - 32'd5; end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      issue(ro, ra, rb);
    end
    drain();
    rand_rdy = 1'b0;
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0 || lat_q.size() != 0) fail_now("scoreboard not empty at end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
